cybercobra_mc: RTL

//  Multicycle, parametrised successor of the CYBERcobra core. Same 32-bit instruction word
//  {J,B,WS[1:0],ALUop[4:0],RA1[4:0],RA2[4:0],offset[7:0],WA[4:0]}. Fetches over a req/valid

---
 rtl/cybercobra_pkg.sv | 44 ++++
 rtl/cobra_alu.sv | 51 +++++
 rtl/cybercobra_mc.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cybercobra_pkg.sv
// Shared encodings for the multicycle CYBERcobra core: instruction fields, ALU opcodes,
// write-select codes and FSM states.
package cybercobra_pkg;

  localparam int unsigned J_BIT     = 31;
  localparam int unsigned B_BIT     = 30;
  localparam int unsigned WS_LSB    = 28;
  localparam int unsigned ALUOP_LSB = 23;
  localparam int unsigned RA1_LSB   = 18;
  localparam int unsigned RA2_LSB   = 13;
  localparam int unsigned OFF_LSB   = 5;
  localparam int unsigned WA_LSB    = 0;
  localparam int unsigned IMM_LSB   = 5;
  localparam int unsigned IMM_WIDTH = 23;

  localparam logic [1:0] WS_IMM  = 2'b00;
  localparam logic [1:0] WS_ALU  = 2'b01;
  localparam logic [1:0] WS_SW   = 2'b10;
  localparam logic [1:0] WS_HALT = 2'b11;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_LT   = 5'b11100;
  localparam logic [4:0] ALU_GE   = 5'b11101;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GEU  = 5'b11111;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec  = 2'b01,
    StHalt  = 2'b10
  } state_e;

endpackage

// File: rtl/cobra_alu.sv
// Combinational ALU: arithmetic/logic ops produce a result, compare ops produce a flag.
module cobra_alu
  import cybercobra_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      op_i,
  output logic [XLEN-1:0] result_o,
  output logic            flag_o
);

  localparam int unsigned ShW = $clog2(XLEN);

  logic [ShW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b_i[ShW-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_EQ:   flag_o   = a_i == b_i;
      ALU_NE:   flag_o   = a_i != b_i;
      ALU_LT:   flag_o   = lt_s;
      ALU_GE:   flag_o   = !lt_s;
      ALU_LTU:  flag_o   = lt_u;
      ALU_GEU:  flag_o   = !lt_u;
      default: begin
        result_o = '0;
        flag_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cybercobra_mc.sv
// Multicycle CYBERcobra core: FETCH over a req/valid instruction port, single-cycle EXEC,
// terminal HALT. Register file and control FSM live here; the ALU is a sub-module.
module cybercobra_mc
  import cybercobra_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned SW_WIDTH  = 16,
  parameter logic [31:0] PC_RESET  = 32'h0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                imem_req_o,
  output logic [31:0]         imem_addr_o,
  input  logic [31:0]         imem_rdata_i,
  input  logic                imem_valid_i,
  output logic [XLEN-1:0]     out_o,
  output logic                retire_o,
  output logic                halt_o
);

  state_e          state_q, state_d;
  logic [31:0]     pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] out_q;
  logic            retire_q;
  logic [XLEN-1:0] rf_q [REG_COUNT];

  logic            j_bit, b_bit, is_halt, take, we;
  logic [1:0]      ws;
  logic [4:0]      alu_op, ra1, ra2, wa;
  logic [7:0]      offset;
  logic [XLEN-1:0] rd1, rd2, wd, imm_ext, sw_ext, alu_res;
  logic            alu_flag;
  logic [31:0]     pc_next, branch_off;

  assign j_bit   = ir_q[J_BIT];
  assign b_bit   = ir_q[B_BIT];
  assign ws      = ir_q[WS_LSB +: 2];
  assign alu_op  = ir_q[ALUOP_LSB +: 5];
  assign ra1     = ir_q[RA1_LSB +: 5];
  assign ra2     = ir_q[RA2_LSB +: 5];
  assign offset  = ir_q[OFF_LSB +: 8];
  assign wa      = ir_q[WA_LSB +: 5];
  assign is_halt = !j_bit && !b_bit && (ws == WS_HALT);

  // Indices that match no implemented register fall through and read as zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (ra1 == 5'(i)) rd1 = rf_q[i];
      if (ra2 == 5'(i)) rd2 = rf_q[i];
    end
  end

  // Sign extension that also truncates when XLEN is narrower than the source.
  always_comb begin
    imm_ext = '0;
    sw_ext  = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      imm_ext[i] = ir_q[IMM_LSB + ((i < int'(IMM_WIDTH)) ? i : int'(IMM_WIDTH) - 1)];
      sw_ext[i]  = sw_i[(i < int'(SW_WIDTH)) ? i : int'(SW_WIDTH) - 1];
    end
  end

  cobra_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a_i      (rd1),
    .b_i      (rd2),
    .op_i     (alu_op),
    .result_o (alu_res),
    .flag_o   (alu_flag)
  );

  always_comb begin
    wd = '0;
    case (ws)
      WS_IMM:  wd = imm_ext;
      WS_ALU:  wd = alu_res;
      WS_SW:   wd = sw_ext;
      default: wd = '0;
    endcase
  end

  assign we = (state_q == StExec) && !j_bit && !b_bit && !is_halt && (wa != 5'd0) &&
              (32'(wa) < REG_COUNT);

  assign branch_off = {{22{offset[7]}}, offset, 2'b00};
  assign take       = j_bit || (b_bit && alu_flag);
  assign pc_next    = take ? (pc_q + branch_off) : (pc_q + 32'd4);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (imem_valid_i) state_d = StExec;
      StExec:  state_d = is_halt ? StHalt : StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StFetch;
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      out_q    <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      retire_q <= 1'b0;
      if (state_q == StFetch && imem_valid_i) ir_q <= imem_rdata_i;
      if (state_q == StExec) begin
        out_q    <= rd1;
        retire_q <= 1'b1;
        if (!is_halt) pc_q <= pc_next;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 1; i < REG_COUNT; i++) begin
        if (wa == 5'(i)) rf_q[i] <= wd;
      end
    end
  end

  assign imem_req_o  = (state_q == StFetch);
  assign imem_addr_o = pc_q;
  assign out_o       = out_q;
  assign retire_o    = retire_q;
  assign halt_o      = (state_q == StHalt);

endmodule
